// File: rtl/hfilter_pkg.sv
// Shared types and arithmetic helpers for the 2D FIR filter stages.
package hfilter_pkg;

    typedef enum logic [1:0] {
        S_FIRST,
        S_RUN,
        S_FLUSH
    } state_t;

    localparam int COEFF_WIDTH_DEF = 14;
    localparam int F = COEFF_WIDTH_DEF - 2;

    // Round half up on frac bits, then clamp to an unsigned dw-bit range.
    function automatic logic signed [31:0] round_sat(
        input logic signed [31:0] sum,
        input int                 frac,
        input int                 dw
    );
        logic signed [31:0] r;
        logic signed [31:0] hi;
        r  = (sum + (32'sd1 <<< (frac - 1))) >>> frac;
        hi = (32'sd1 <<< dw) - 32'sd1;
        if (r < 0)
            round_sat = '0;
        else if (r > hi)
            round_sat = hi;
        else
            round_sat = r;
    endfunction

endpackage

// File: rtl/hfilter_mac3.sv
// 3-tap multiply / sum / round-saturate pipeline (two register stages).
module hfilter_mac3
    import hfilter_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic [DATA_WIDTH-1:0]  l_i,
    input  logic [DATA_WIDTH-1:0]  c_i,
    input  logic [DATA_WIDTH-1:0]  r_i,
    input  logic [DATA_WIDTH-1:0]  center_i,
    input  logic                   eol_i,
    input  logic [COEFF_WIDTH-1:0] coeff0_i,
    input  logic [COEFF_WIDTH-1:0] coeff1_i,
    input  logic [COEFF_WIDTH-1:0] coeff2_i,
    output logic                   valid_o,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic [DATA_WIDTH-1:0]  center_o,
    output logic                   eol_o
);

    localparam int PW = DATA_WIDTH + COEFF_WIDTH + 1;
    localparam int SW = DATA_WIDTH + COEFF_WIDTH + 3;
    localparam int FR = COEFF_WIDTH - 2;

    logic                  pv_q, pv_d, peol_q, peol_d;
    logic signed [PW-1:0]  p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
    logic [DATA_WIDTH-1:0] pcen_q, pcen_d;
    logic                  sv_q, sv_d, seol_q, seol_d;
    logic signed [SW-1:0]  sum_q, sum_d;
    logic [DATA_WIDTH-1:0] scen_q, scen_d;

    always_comb begin
        pv_d   = valid_i;
        peol_d = valid_i & eol_i;
        p0_d   = p0_q;
        p1_d   = p1_q;
        p2_d   = p2_q;
        pcen_d = pcen_q;
        if (valid_i) begin
            p0_d   = PW'($signed({1'b0, l_i})) * PW'($signed(coeff0_i));
            p1_d   = PW'($signed({1'b0, c_i})) * PW'($signed(coeff1_i));
            p2_d   = PW'($signed({1'b0, r_i})) * PW'($signed(coeff2_i));
            pcen_d = center_i;
        end
        sv_d   = pv_q;
        seol_d = pv_q & peol_q;
        sum_d  = sum_q;
        scen_d = scen_q;
        if (pv_q) begin
            sum_d  = SW'(p0_q) + SW'(p1_q) + SW'(p2_q);
            scen_d = pcen_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q   <= 1'b0;
            peol_q <= 1'b0;
            p0_q   <= '0;
            p1_q   <= '0;
            p2_q   <= '0;
            pcen_q <= '0;
            sv_q   <= 1'b0;
            seol_q <= 1'b0;
            sum_q  <= '0;
            scen_q <= '0;
        end else begin
            pv_q   <= pv_d;
            peol_q <= peol_d;
            p0_q   <= p0_d;
            p1_q   <= p1_d;
            p2_q   <= p2_d;
            pcen_q <= pcen_d;
            sv_q   <= sv_d;
            seol_q <= seol_d;
            sum_q  <= sum_d;
            scen_q <= scen_d;
        end
    end

    assign valid_o  = sv_q;
    assign eol_o    = seol_q;
    assign center_o = scen_q;
    assign data_o   = DATA_WIDTH'(round_sat(32'(sum_q), FR, DATA_WIDTH));

endmodule

// File: rtl/hfilter_h3.sv
// Horizontal 3-tap FIR stage: line windowing with border replication.
module hfilter_h3
    import hfilter_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 14,
    parameter int CNT_WIDTH   = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic [DATA_WIDTH-1:0]  center_i,
    input  logic [CNT_WIDTH-1:0]   line_width_i,
    input  logic [COEFF_WIDTH-1:0] coeff0_h_i,
    input  logic [COEFF_WIDTH-1:0] coeff1_h_i,
    input  logic [COEFF_WIDTH-1:0] coeff2_h_i,
    output logic                   valid_o,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic [DATA_WIDTH-1:0]  center_o,
    output logic                   eol_o
);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, width_q, width_d;
    logic [DATA_WIDTH-1:0] win_l_q, win_l_d, win_c_q, win_c_d;
    logic [DATA_WIDTH-1:0] cen_c_q, cen_c_d;
    logic                  accept, iss, iss_eol;
    logic [DATA_WIDTH-1:0] iss_r;
    logic                  wv_q, wv_d, weol_q, weol_d;
    logic [DATA_WIDTH-1:0] wl_q, wl_d, wc_q, wc_d;
    logic [DATA_WIDTH-1:0] wr_q, wr_d, wcen_q, wcen_d;

    assign ready_o = (state_q != S_FLUSH);
    assign accept  = valid_i && ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        win_l_d = win_l_q;
        win_c_d = win_c_q;
        cen_c_d = cen_c_q;
        iss     = 1'b0;
        iss_r   = data_i;
        iss_eol = 1'b0;
        unique case (state_q)
            S_FIRST: begin
                if (accept) begin
                    win_l_d = data_i;
                    win_c_d = data_i;
                    cen_c_d = center_i;
                    width_d = line_width_i;
                    cnt_d   = CNT_WIDTH'(1);
                    state_d = (line_width_i == CNT_WIDTH'(1)) ? S_FLUSH : S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    iss     = 1'b1;
                    win_l_d = win_c_q;
                    win_c_d = data_i;
                    cen_c_d = center_i;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == width_q - 1'b1)
                        state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Right border: replicate the last pixel into the right tap.
                iss     = 1'b1;
                iss_r   = win_c_q;
                iss_eol = 1'b1;
                cnt_d   = '0;
                state_d = S_FIRST;
            end
            default: state_d = S_FIRST;
        endcase
        wv_d   = iss;
        weol_d = iss & iss_eol;
        wl_d   = iss ? win_l_q : wl_q;
        wc_d   = iss ? win_c_q : wc_q;
        wr_d   = iss ? iss_r : wr_q;
        wcen_d = iss ? cen_c_q : wcen_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FIRST;
            cnt_q   <= '0;
            width_q <= '0;
            win_l_q <= '0;
            win_c_q <= '0;
            cen_c_q <= '0;
            wv_q    <= 1'b0;
            weol_q  <= 1'b0;
            wl_q    <= '0;
            wc_q    <= '0;
            wr_q    <= '0;
            wcen_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            win_l_q <= win_l_d;
            win_c_q <= win_c_d;
            cen_c_q <= cen_c_d;
            wv_q    <= wv_d;
            weol_q  <= weol_d;
            wl_q    <= wl_d;
            wc_q    <= wc_d;
            wr_q    <= wr_d;
            wcen_q  <= wcen_d;
        end
    end

    hfilter_mac3 #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEFF_WIDTH(COEFF_WIDTH)
    ) u_mac3 (
        .clk     (clk),
        .rst     (rst),
        .valid_i (wv_q),
        .l_i     (wl_q),
        .c_i     (wc_q),
        .r_i     (wr_q),
        .center_i(wcen_q),
        .eol_i   (weol_q),
        .coeff0_i(coeff0_h_i),
        .coeff1_i(coeff1_h_i),
        .coeff2_i(coeff2_h_i),
        .valid_o (valid_o),
        .data_o  (data_o),
        .center_o(center_o),
        .eol_o   (eol_o)
    );

endmodule

// File: tb/tb_hfilter_h3.sv
// Bench for hfilter_h3: directed table, corner sequences, random lines vs model.
module tb_hfilter_h3;
    import hfilter_pkg::*;

    localparam int DW = 8;
    localparam int CW = 14;
    localparam int NW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [DW-1:0] data_i = '0;
    logic [DW-1:0] center_i = '0;
    logic [NW-1:0] line_width_i = '0;
    logic [CW-1:0] coeff0_h_i = '0;
    logic [CW-1:0] coeff1_h_i = '0;
    logic [CW-1:0] coeff2_h_i = '0;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic [DW-1:0] center_o;
    logic          eol_o;

    hfilter_h3 dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .center_i    (center_i),
        .line_width_i(line_width_i),
        .coeff0_h_i  (coeff0_h_i),
        .coeff1_h_i  (coeff1_h_i),
        .coeff2_h_i  (coeff2_h_i),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .center_o    (center_o),
        .eol_o       (eol_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int d;
        int c;
        int e;
        int t;
    } obs_t;
    obs_t got[$];

    always @(negedge clk)
        if (!rst && valid_o)
            got.push_back('{int'(data_o), int'(center_o), int'(eol_o), cyc});

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_coeffs(input int k0, input int k1, input int k2);
        coeff0_h_i = CW'(k0);
        coeff1_h_i = CW'(k1);
        coeff2_h_i = CW'(k2);
    endtask

    // Offer one pixel; returns the cycle it was accepted in (-1 on timeout).
    task automatic push(input int d, input int c, output int t);
        bit r;
        int g;
        g = 0;
        t = -1;
        valid_i  = 1'b1;
        data_i   = DW'(d);
        center_i = DW'(c);
        while (t < 0 && g < 20) begin
            r = ready_o;
            if (r) t = cyc;
            @(posedge clk);
            @(negedge clk);
            g++;
        end
        if (t < 0) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_outputs(input int n);
        int g;
        g = 0;
        while (got.size() < n && g < 60) begin
            @(negedge clk);
            g++;
        end
        repeat (4) @(negedge clk);
    endtask

    int lpx[16];
    int lcen[16];
    int lexp[16];

    // Expected pixel from the filter definition: replicated borders, round, clamp.
    function automatic int model_px(input int i, input int w);
        int k0, k1, k2, l, c, r, s, q;
        k0 = $signed(coeff0_h_i);
        k1 = $signed(coeff1_h_i);
        k2 = $signed(coeff2_h_i);
        l = lpx[(i == 0) ? 0 : i - 1];
        c = lpx[i];
        r = lpx[(i == w - 1) ? w - 1 : i + 1];
        s = k0 * l + k1 * c + k2 * r;
        q = (s + (1 <<< (F - 1))) >>> F;
        if (q < 0) q = 0;
        if (q > 255) q = 255;
        return q;
    endfunction

    task automatic run_line(input string nm, input int w, input int maxgap);
        int t;
        got.delete();
        for (int i = 0; i < w; i++) begin
            if (i == 0) line_width_i = NW'(w);
            push(lpx[i], lcen[i], t);
            line_width_i = NW'($urandom_range(1, 4095));
            if (maxgap > 0) begin
                valid_i = 1'b0;
                repeat ($urandom_range(0, maxgap)) @(negedge clk);
            end
        end
        valid_i = 1'b0;
        wait_outputs(w);
        chk({nm, "_count"}, got.size(), w);
        for (int i = 0; i < w && i < got.size(); i++) begin
            chk($sformatf("%s_data%0d", nm, i), got[i].d, lexp[i]);
            chk($sformatf("%s_cen%0d", nm, i), got[i].c, lcen[i]);
            chk($sformatf("%s_eol%0d", nm, i), got[i].e, (i == w - 1) ? 1 : 0);
        end
    endtask

    typedef struct {
        int w;
        int k0;
        int k1;
        int k2;
        int px[4];
        int ex[4];
    } vec_t;
    vec_t tbl[7];

    initial begin
        int t0, t1, t2, t3, t5, t9, w;

        tbl[0] = '{4, 0, 4096, 0, '{10, 20, 30, 40}, '{10, 20, 30, 40}};
        tbl[1] = '{3, 1365, 1365, 1365, '{30, 60, 90, 0}, '{40, 60, 80, 0}};
        tbl[2] = '{1, 0, 2048, 0, '{3, 0, 0, 0}, '{2, 0, 0, 0}};
        tbl[3] = '{1, 0, 8191, 0, '{200, 0, 0, 0}, '{255, 0, 0, 0}};
        tbl[4] = '{1, 0, 'h3000, 0, '{100, 0, 0, 0}, '{0, 0, 0, 0}};
        tbl[5] = '{1, 0, 4096, 0, '{77, 0, 0, 0}, '{77, 0, 0, 0}};
        tbl[6] = '{2, 0, 4096, 0, '{5, 6, 0, 0}, '{5, 6, 0, 0}};

        repeat (3) @(negedge clk);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_center", center_o, 0);
        chk("rst_eol", eol_o, 0);
        chk("rst_ready", ready_o, 1);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            set_coeffs(tbl[v].k0, tbl[v].k1, tbl[v].k2);
            for (int i = 0; i < 4; i++) begin
                lpx[i]  = tbl[v].px[i];
                lcen[i] = (tbl[v].px[i] * 7 + 3) & 255;
                lexp[i] = tbl[v].ex[i];
            end
            run_line($sformatf("tbl%0d", v), tbl[v].w, 0);
        end

        // Same box line with gaps in valid_i.
        set_coeffs(1365, 1365, 1365);
        for (int i = 0; i < 3; i++) begin
            lpx[i]  = tbl[1].px[i];
            lcen[i] = i + 100;
            lexp[i] = tbl[1].ex[i];
        end
        run_line("box_gaps", 3, 3);

        // Latency and single flush cycle on a back-to-back identity line.
        set_coeffs(0, 4096, 0);
        got.delete();
        line_width_i = NW'(4);
        push(10, 1, t0);
        push(20, 2, t1);
        push(30, 3, t2);
        push(40, 4, t3);
        chk("ready_flush", ready_o, 0);
        valid_i = 1'b0;
        @(negedge clk);
        chk("ready_after_flush", ready_o, 1);
        wait_outputs(4);
        chk("lat_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            chk($sformatf("lat_cycle%0d", i), got[i].t - t0, i + 4);
            chk($sformatf("lat_data%0d", i), got[i].d, 10 * (i + 1));
        end

        // valid_i held through the flush: next pixel waits one cycle.
        got.delete();
        line_width_i = NW'(2);
        push(8, 8, t0);
        line_width_i = NW'(9);
        push(9, 9, t9);
        line_width_i = NW'(2);
        push(5, 5, t5);
        chk("held_accept_gap", t5 - t9, 2);
        line_width_i = NW'(7);
        push(6, 6, t1);
        valid_i = 1'b0;
        wait_outputs(4);
        chk("held_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            chk($sformatf("held_data%0d", i), got[i].d, (i < 2) ? 8 + i : 5 + (i - 2));
            chk($sformatf("held_eol%0d", i), got[i].e, i % 2);
        end

        // Reset mid-line after two pixels.
        got.delete();
        set_coeffs(0, 4096, 0);
        line_width_i = NW'(4);
        push(111, 11, t0);
        push(222, 22, t1);
        valid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_data", data_o, 0);
        chk("mid_rst_center", center_o, 0);
        chk("mid_rst_eol", eol_o, 0);
        chk("mid_rst_ready", ready_o, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_coeffs(1365, 1365, 1365);
        for (int i = 0; i < 3; i++) begin
            lpx[i]  = tbl[1].px[i];
            lcen[i] = 200 + i;
            lexp[i] = tbl[1].ex[i];
        end
        run_line("post_rst", 3, 0);

        // Random lines against the behavioural model.
        for (int n = 0; n < 40; n++) begin
            w = $urandom_range(1, 9);
            set_coeffs(($urandom_range(0, 3) == 0) ? $urandom_range(0, 16383) : $urandom_range(0, 2000),
                       ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16383) : $urandom_range(0, 4096),
                       ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16383) : $urandom_range(0, 2000));
            for (int i = 0; i < w; i++) begin
                lpx[i]  = $urandom_range(0, 255);
                lcen[i] = $urandom_range(0, 255);
            end
            for (int i = 0; i < w; i++) lexp[i] = model_px(i, w);
            run_line($sformatf("rnd%0d", n), w, n % 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
